// File: rtl/ysyx_25040111_mem_arb.sv
// ysyx_25040111_mem_arb: N-channel burst arbiter (fixed or round-robin) in front of the LSU master port.
module ysyx_25040111_mem_arb #(
    parameter int NUM_CH  = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR_MODE = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    s_req,
    input  logic [NUM_CH-1:0]    s_wen,
    input  logic [NUM_CH-1:0]    s_ren,
    input  logic [NUM_CH-1:0]    s_sign,
    input  logic [2*NUM_CH-1:0]  s_mask,
    input  logic [8*NUM_CH-1:0]  s_tlen,
    input  logic [AW*NUM_CH-1:0] s_addr,
    input  logic [DW*NUM_CH-1:0] s_wdata,
    output logic [NUM_CH-1:0]    s_grant,
    output logic [NUM_CH-1:0]    s_ok,
    output logic [NUM_CH-1:0]    s_done,
    output logic [DW-1:0]        s_rdata,
    output logic                 m_start,
    output logic                 m_wen,
    output logic                 m_ren,
    output logic                 m_sign,
    output logic [1:0]           m_mask,
    output logic [7:0]           m_tlen,
    output logic [AW-1:0]        m_addr,
    output logic [DW-1:0]        m_wdata,
    input  logic                 m_ok,
    input  logic [DW-1:0]        m_rdata,
    output logic                 busy
);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] own_q, own_d, rr_ptr_q, rr_ptr_d, win, start;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [7:0] beat_q, beat_d, m_tlen_q, m_tlen_d;
    logic m_wen_q, m_wen_d, m_ren_q, m_ren_d, m_sign_q, m_sign_d;
    logic [1:0] m_mask_q, m_mask_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic fire, last;
    int w;

    // Scan from the start pointer downwards so the first set index at or after it wins last.
    always_comb begin
        start = RR_MODE != 0 ? rr_ptr_q : '0;
        win = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (s_req[(int'(start) + k) % NUM_CH]) win = IW'((int'(start) + k) % NUM_CH);
    end

    assign fire    = state_q == WAIT && m_ok;
    assign last    = beat_q == m_tlen_q;
    assign s_grant = grant_q;
    assign s_ok    = fire ? grant_q : '0;
    assign s_done  = fire && last ? grant_q : '0;
    assign s_rdata = fire ? m_rdata : '0;
    assign m_start = state_q == ISSUE;
    assign busy    = state_q != IDLE;
    assign m_wen   = m_wen_q;
    assign m_ren   = m_ren_q;
    assign m_sign  = m_sign_q;
    assign m_mask  = m_mask_q;
    assign m_tlen  = m_tlen_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        m_wen_d   = m_wen_q;
        m_ren_d   = m_ren_q;
        m_sign_d  = m_sign_q;
        m_mask_d  = m_mask_q;
        m_tlen_d  = m_tlen_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        w         = int'(win);
        case (state_q)
            IDLE: if (|s_req) begin
                state_d    = ISSUE;
                own_d      = win;
                grant_d    = '0;
                grant_d[w] = 1'b1;
                m_wen_d    = s_wen[w];
                m_ren_d    = s_ren[w] & ~s_wen[w];
                m_sign_d   = s_sign[w];
                m_mask_d   = s_mask[2*w +: 2];
                m_tlen_d   = s_wen[w] ? 8'd0 : s_tlen[8*w +: 8];
                m_addr_d   = s_addr[AW*w +: AW];
                m_wdata_d  = s_wdata[DW*w +: DW];
            end
            ISSUE: state_d = WAIT;
            WAIT: if (m_ok) begin
                beat_d = beat_q + 8'd1;
                if (last) begin
                    state_d  = IDLE;
                    beat_d   = '0;
                    grant_d  = '0;
                    rr_ptr_d = own_q == IW'(NUM_CH - 1) ? '0 : own_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            own_q     <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            beat_q    <= '0;
            m_wen_q   <= 1'b0;
            m_ren_q   <= 1'b0;
            m_sign_q  <= 1'b0;
            m_mask_q  <= '0;
            m_tlen_q  <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            m_wen_q   <= m_wen_d;
            m_ren_q   <= m_ren_d;
            m_sign_q  <= m_sign_d;
            m_mask_q  <= m_mask_d;
            m_tlen_q  <= m_tlen_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end
endmodule

// File: tb/tb_ysyx_25040111_mem_arb.sv
// tb_ysyx_25040111_mem_arb: scenario bench for the memory arbiter, 2-channel RR plus 3-channel RR/fixed pair.
module tb_ysyx_25040111_mem_arb;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]  s_req = '0, s_wen = '0, s_ren = '0, s_sign = '0;
    logic [3:0]  s_mask = '0;
    logic [15:0] s_tlen = '0;
    logic [63:0] s_addr = '0, s_wdata = '0;
    logic [1:0]  s_grant, s_ok, s_done;
    logic [31:0] s_rdata, m_addr, m_wdata, m_rdata = '0;
    logic        m_start, m_wen, m_ren, m_sign, busy, m_ok = 1'b0;
    logic [1:0]  m_mask;
    logic [7:0]  m_tlen;

    ysyx_25040111_mem_arb #(.NUM_CH(2), .RR_MODE(1)) dut (
        .clock(clock), .reset(reset), .s_req(s_req), .s_wen(s_wen), .s_ren(s_ren), .s_sign(s_sign),
        .s_mask(s_mask), .s_tlen(s_tlen), .s_addr(s_addr), .s_wdata(s_wdata), .s_grant(s_grant),
        .s_ok(s_ok), .s_done(s_done), .s_rdata(s_rdata), .m_start(m_start), .m_wen(m_wen), .m_ren(m_ren),
        .m_sign(m_sign), .m_mask(m_mask), .m_tlen(m_tlen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ok(m_ok), .m_rdata(m_rdata), .busy(busy));

    logic [2:0]  r3_req = '0, r3_ren = '0;
    logic        r3_ok = 1'b0;
    logic [2:0]  rr_grant, rr_ok, rr_done, fx_grant, fx_ok, fx_done;
    logic [31:0] rr_rdata, rr_addr, rr_wdata, fx_rdata, fx_addr, fx_wdata;
    logic        rr_start, rr_wen, rr_ren, rr_sign, rr_busy, fx_start, fx_wen, fx_ren, fx_sign, fx_busy;
    logic [1:0]  rr_mask, fx_mask;
    logic [7:0]  rr_tlen, fx_tlen;

    ysyx_25040111_mem_arb #(.NUM_CH(3), .RR_MODE(1)) u_rr (
        .clock(clock), .reset(reset), .s_req(r3_req), .s_wen(3'b000), .s_ren(r3_ren), .s_sign(3'b000),
        .s_mask(6'd0), .s_tlen(24'd0), .s_addr(96'd0), .s_wdata(96'd0), .s_grant(rr_grant),
        .s_ok(rr_ok), .s_done(rr_done), .s_rdata(rr_rdata), .m_start(rr_start), .m_wen(rr_wen),
        .m_ren(rr_ren), .m_sign(rr_sign), .m_mask(rr_mask), .m_tlen(rr_tlen), .m_addr(rr_addr),
        .m_wdata(rr_wdata), .m_ok(r3_ok), .m_rdata(32'h0), .busy(rr_busy));

    ysyx_25040111_mem_arb #(.NUM_CH(3), .RR_MODE(0)) u_fx (
        .clock(clock), .reset(reset), .s_req(r3_req), .s_wen(3'b000), .s_ren(r3_ren), .s_sign(3'b000),
        .s_mask(6'd0), .s_tlen(24'd0), .s_addr(96'd0), .s_wdata(96'd0), .s_grant(fx_grant),
        .s_ok(fx_ok), .s_done(fx_done), .s_rdata(fx_rdata), .m_start(fx_start), .m_wen(fx_wen),
        .m_ren(fx_ren), .m_sign(fx_sign), .m_mask(fx_mask), .m_tlen(fx_tlen), .m_addr(fx_addr),
        .m_wdata(fx_wdata), .m_ok(r3_ok), .m_rdata(32'h0), .busy(fx_busy));

    typedef struct packed {logic [1:0] ok; logic [1:0] done; logic [31:0] rdata;} exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, failures = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [1:0] ok, input logic [1:0] done);
        m_ok = 1'b1;
        m_rdata = d;
        sb.push_back('{ok: ok, done: done, rdata: d});
    endtask

    task automatic test_reset();
        reset = 1'b0; s_req = 2'b11; s_ren = 2'b11; s_addr = 64'h1111_2222_3333_4444;
        m_ok = 1'b1; m_rdata = 32'h1234_5678;
        repeat (3) step();
        @(negedge clock);
        checks += 6;
        if (s_grant !== 2'b00) begin failures++; $display("FAIL rst_grant got %b exp 00", s_grant); end
        if (s_ok !== 2'b00 || s_done !== 2'b00) begin failures++; $display("FAIL rst_ok got ok=%b done=%b exp 00", s_ok, s_done); end
        if (s_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got %h exp 0", s_rdata); end
        if (m_start !== 1'b0) begin failures++; $display("FAIL rst_start got %b exp 0", m_start); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (m_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got %h exp 0", m_addr); end
        m_ok = 1'b0; s_req = '0; s_ren = '0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        s_addr[63:32] = 32'h8000_0010; s_tlen[15:8] = 8'd0; s_ren[1] = 1'b1; s_req[1] = 1'b1;
        step();
        @(negedge clock);
        checks += 4;
        if (s_grant !== 2'b10) begin failures++; $display("FAIL rd_grant got %b exp 10", s_grant); end
        if (m_start !== 1'b1) begin failures++; $display("FAIL rd_start got %b exp 1", m_start); end
        if (m_addr !== 32'h8000_0010) begin failures++; $display("FAIL rd_addr got %h exp 80000010", m_addr); end
        if (m_ren !== 1'b1 || m_wen !== 1'b0) begin failures++; $display("FAIL rd_type got ren=%b wen=%b exp 1/0", m_ren, m_wen); end
        step();
        @(negedge clock);
        checks += 2;
        if (m_start !== 1'b0) begin failures++; $display("FAIL rd_start_pulse got %b exp 0", m_start); end
        if (s_ok !== 2'b00) begin failures++; $display("FAIL rd_early_ok got %b exp 00", s_ok); end
        step(); step();
        push_beat(32'hDEAD_BEEF, 2'b10, 2'b10);
        @(negedge clock);
        e = sb.pop_front();
        checks += 3;
        if (s_ok !== e.ok) begin failures++; $display("FAIL rd_ok got %b exp %b", s_ok, e.ok); end
        if (s_done !== e.done) begin failures++; $display("FAIL rd_done got %b exp %b", s_done, e.done); end
        if (s_rdata !== e.rdata) begin failures++; $display("FAIL rd_rdata got %h exp %h", s_rdata, e.rdata); end
        step();
        m_ok = 1'b0; s_req = '0; s_ren = '0;
        @(negedge clock);
        checks += 1;
        if (busy !== 1'b0 || s_grant !== 2'b00) begin failures++; $display("FAIL rd_idle got busy=%b grant=%b exp 0/00", busy, s_grant); end
    endtask

    task automatic test_burst();
        s_addr[31:0] = 32'h8000_1000; s_tlen[7:0] = 8'd7; s_ren[0] = 1'b1; s_req[0] = 1'b1;
        step();
        @(negedge clock);
        checks += 2;
        if (s_grant !== 2'b01) begin failures++; $display("FAIL bu_grant got %b exp 01", s_grant); end
        if (m_tlen !== 8'd7) begin failures++; $display("FAIL bu_tlen got %0d exp 7", m_tlen); end
        step();
        s_req[1] = 1'b1; s_ren[1] = 1'b1; s_tlen[15:8] = 8'd0; s_addr[31:0] = 32'hBAD0_0000;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 4) begin
                m_ok = 1'b0;
                @(negedge clock);
                checks += 1;
                if (s_ok !== 2'b00) begin failures++; $display("FAIL bu_gap_ok got %b exp 00", s_ok); end
                step();
            end
            push_beat(32'hA000_0000 + i, 2'b01, i == 7 ? 2'b01 : 2'b00);
            @(negedge clock);
            e = sb.pop_front();
            checks += 5;
            if (s_ok !== e.ok) begin failures++; $display("FAIL bu_ok[%0d] got %b exp %b", i, s_ok, e.ok); end
            if (s_done !== e.done) begin failures++; $display("FAIL bu_done[%0d] got %b exp %b", i, s_done, e.done); end
            if (s_rdata !== e.rdata) begin failures++; $display("FAIL bu_rdata[%0d] got %h exp %h", i, s_rdata, e.rdata); end
            if (s_grant !== 2'b01) begin failures++; $display("FAIL bu_hold[%0d] got %b exp 01", i, s_grant); end
            if (m_addr !== 32'h8000_1000) begin failures++; $display("FAIL bu_addr[%0d] got %h exp 80001000", i, m_addr); end
        end
        step();
        m_ok = 1'b0; s_req[0] = 1'b0; s_ren[0] = 1'b0;
        @(negedge clock);
        checks += 1;
        if (s_grant !== 2'b00) begin failures++; $display("FAIL bu_bubble got %b exp 00", s_grant); end
        step();
        @(negedge clock);
        checks += 1;
        if (s_grant !== 2'b10) begin failures++; $display("FAIL bu_next_grant got %b exp 10", s_grant); end
        step(); step();
        push_beat(32'h5555_AAAA, 2'b10, 2'b10);
        @(negedge clock);
        e = sb.pop_front();
        checks += 3;
        if (s_ok !== e.ok) begin failures++; $display("FAIL bu2_ok got %b exp %b", s_ok, e.ok); end
        if (s_done !== e.done) begin failures++; $display("FAIL bu2_done got %b exp %b", s_done, e.done); end
        if (s_rdata !== e.rdata) begin failures++; $display("FAIL bu2_rdata got %h exp %h", s_rdata, e.rdata); end
        step();
        m_ok = 1'b0; s_req = '0; s_ren = '0;
    endtask

    task automatic test_write();
        s_wen[1] = 1'b1; s_ren[1] = 1'b1; s_tlen[15:8] = 8'd5; s_mask[3:2] = 2'b01;
        s_wdata[63:32] = 32'hCAFE_F00D; s_req[1] = 1'b1;
        step();
        @(negedge clock);
        checks += 4;
        if (m_wen !== 1'b1 || m_ren !== 1'b0) begin failures++; $display("FAIL wr_type got wen=%b ren=%b exp 1/0", m_wen, m_ren); end
        if (m_tlen !== 8'd0) begin failures++; $display("FAIL wr_tlen got %0d exp 0", m_tlen); end
        if (m_wdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr_wdata got %h exp cafef00d", m_wdata); end
        if (m_mask !== 2'b01) begin failures++; $display("FAIL wr_mask got %b exp 01", m_mask); end
        step(); step();
        push_beat(32'h1111_2222, 2'b10, 2'b10);
        @(negedge clock);
        e = sb.pop_front();
        checks += 3;
        if (s_ok !== e.ok) begin failures++; $display("FAIL wr_ok got %b exp %b", s_ok, e.ok); end
        if (s_done !== e.done) begin failures++; $display("FAIL wr_done got %b exp %b", s_done, e.done); end
        if (s_rdata !== e.rdata) begin failures++; $display("FAIL wr_rdata got %h exp %h", s_rdata, e.rdata); end
        step();
        m_ok = 1'b0; s_req = '0; s_wen = '0; s_ren = '0;
        @(negedge clock);
        checks += 1;
        if (busy !== 1'b0) begin failures++; $display("FAIL wr_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_wait();
        s_tlen = 16'h0300; s_req = 2'b01; s_ren = 2'b01;
        step(); step(); step();
        push_beat(32'h0000_0077, 2'b01, 2'b01);
        @(negedge clock);
        e = sb.pop_front();
        checks += 2;
        if (s_ok !== e.ok || s_done !== e.done) begin failures++; $display("FAIL rw_pre got ok=%b done=%b exp %b/%b", s_ok, s_done, e.ok, e.done); end
        if (s_rdata !== e.rdata) begin failures++; $display("FAIL rw_pre_rdata got %h exp %h", s_rdata, e.rdata); end
        step();
        m_ok = 1'b0; s_req = 2'b10; s_ren = 2'b10;
        step(); step(); step();
        push_beat(32'h0000_0088, 2'b10, 2'b00);
        @(negedge clock);
        e = sb.pop_front();
        checks += 1;
        if (s_ok !== e.ok || s_done !== e.done) begin failures++; $display("FAIL rw_mid got ok=%b done=%b exp %b/%b", s_ok, s_done, e.ok, e.done); end
        step();
        m_ok = 1'b0;
        #1 reset = 1'b0;
        #1;
        checks += 1;
        if (busy !== 1'b0 || s_grant !== 2'b00) begin failures++; $display("FAIL rw_async got busy=%b grant=%b exp 0/00", busy, s_grant); end
        s_req = '0; s_ren = '0; m_ok = 1'b1; m_rdata = 32'h0000_0099;
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clock);
            checks += 1;
            if (s_ok !== 2'b00 || s_rdata !== 32'h0 || busy !== 1'b0) begin
                failures++; $display("FAIL rw_stale[%0d] got ok=%b rdata=%h busy=%b exp 00/0/0", i, s_ok, s_rdata, busy);
            end
        end
        m_ok = 1'b0; s_tlen = '0; s_req = 2'b11; s_ren = 2'b11;
        step();
        @(negedge clock);
        checks += 1;
        if (s_grant !== 2'b01) begin failures++; $display("FAIL rw_ptr got %b exp 01", s_grant); end
        step(); step();
        push_beat(32'h0000_0066, 2'b01, 2'b01);
        @(negedge clock);
        e = sb.pop_front();
        checks += 1;
        if (s_done !== e.done) begin failures++; $display("FAIL rw_post_done got %b exp %b", s_done, e.done); end
        step();
        m_ok = 1'b0; s_req = '0; s_ren = '0;
        step();
    endtask

    task automatic test_rr();
        logic [2:0] exp_rr [4];
        int n;
        exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
        r3_req = 3'b111; r3_ren = 3'b111;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (rr_grant === 3'b000 && n < 10) begin step(); n++; end
            checks += 1;
            if (n >= 10) begin failures++; $display("FAIL rr_timeout[%0d] got grant=%b exp nonzero", t, rr_grant); end
            @(negedge clock);
            checks += 2;
            if (rr_grant !== exp_rr[t]) begin failures++; $display("FAIL rr_order[%0d] got %b exp %b", t, rr_grant, exp_rr[t]); end
            if (fx_grant !== 3'b001) begin failures++; $display("FAIL fx_order[%0d] got %b exp 001", t, fx_grant); end
            step(); step();
            r3_ok = 1'b1;
            @(negedge clock);
            checks += 1;
            if (rr_done !== exp_rr[t]) begin failures++; $display("FAIL rr_done[%0d] got %b exp %b", t, rr_done, exp_rr[t]); end
            step();
            r3_ok = 1'b0;
        end
        r3_req = '0; r3_ren = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst();
        test_write();
        test_reset_wait();
        test_rr();
        checks += 1;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
